// File: rtl/mem_stage_bw_if.sv
// Bundle between the EX/MEM register, the MEM stage and the WB mux.
// Handshake: mem_stall is a combinational "not ready". While it is high the
// upstream stage must hold every XM_* field and ALUout stable; the access
// retires on the first rising edge at which mem_stall is low.
interface mem_stage_bw_if;
    logic        XM_MemtoReg;
    logic        XM_RegWrite;
    logic        XM_MemRead;
    logic        XM_MemWrite;
    logic [1:0]  XM_Size;
    logic        XM_Unsigned;
    logic [31:0] ALUout;
    logic [4:0]  XM_RD;
    logic [31:0] XM_MD;
    logic        MW_MemtoReg;
    logic        MW_RegWrite;
    logic [31:0] MW_ALUout;
    logic [31:0] MDR;
    logic [4:0]  MW_RD;
    logic        MW_Misalign;
    logic        mem_stall;

    modport master (
        output XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_Size,
               XM_Unsigned, ALUout, XM_RD, XM_MD,
        input  MW_MemtoReg, MW_RegWrite, MW_ALUout, MDR, MW_RD, MW_Misalign,
               mem_stall
    );

    modport slave (
        input  XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_Size,
               XM_Unsigned, ALUout, XM_RD, XM_MD,
        output MW_MemtoReg, MW_RegWrite, MW_ALUout, MDR, MW_RD, MW_Misalign,
               mem_stall
    );
endinterface

// File: rtl/mem_stage_bw.sv
// MEM pipeline stage: byte-addressable data memory with sized, sign/zero
// extended loads, misalignment trapping, configurable access latency and the
// MEM/WB pipeline register.
module mem_stage_bw #(
    parameter int DEPTH   = 128,
    parameter int MEM_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_stage_bw_if.slave        bus,
    output logic                 dbg_state,
    output logic [2:0]           dbg_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] LAT_M1 = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [31:0] dm [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          access, is_store, is_load, misalign, retire, dm_we;
    logic [31:0]   rd_word, ld_ext, wr_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [3:0]    wr_be;
    logic          unused_addr;

    logic        mw_memtoreg_q, mw_memtoreg_d;
    logic        mw_regwrite_q, mw_regwrite_d;
    logic [31:0] mw_aluout_q, mw_aluout_d;
    logic [31:0] mdr_q, mdr_d;
    logic [4:0]  mw_rd_q, mw_rd_d;
    logic        mw_misalign_q, mw_misalign_d;

    assign idx         = bus.ALUout[AW+1:2];
    assign lane        = bus.ALUout[1:0];
    assign unused_addr = ^bus.ALUout[31:AW+2];

    // Decode the access type and alignment trap.
    always_comb begin
        access   = bus.XM_MemRead | bus.XM_MemWrite;
        is_store = bus.XM_MemWrite;
        is_load  = bus.XM_MemRead & ~bus.XM_MemWrite;
        misalign = 1'b0;
        if (access) begin
            if (bus.XM_Size == 2'b01)
                misalign = lane[0];
            else if (bus.XM_Size[1])
                misalign = (lane != 2'b00);
        end
    end

    // Stall while the access is waiting; held low in reset so nothing upstream freezes.
    always_comb begin
        retire        = 1'b1;
        bus.mem_stall = 1'b0;
        if (MEM_LAT != 0 && rst) begin
            if ((state_q == S_IDLE && access) || (state_q == S_WAIT && cnt_q != 3'd0))
                bus.mem_stall = 1'b1;
        end
        retire = ~bus.mem_stall;
    end

    // Next state of the latency FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (access && MEM_LAT != 0) begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 3'd0)
                    cnt_d = cnt_q - 3'd1;
                else
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latency FSM state and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

    // Load lane selection and extension.
    always_comb begin
        rd_word = dm[idx];
        case (lane)
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.XM_Size)
            2'b00:   ld_ext = bus.XM_Unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = bus.XM_Unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = rd_word;
        endcase
    end

    // Store data replication and byte enables.
    always_comb begin
        case (bus.XM_Size)
            2'b00: begin
                wr_data = {4{bus.XM_MD[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            2'b01: begin
                wr_data = {2{bus.XM_MD[15:0]}};
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = bus.XM_MD;
                wr_be   = 4'b1111;
            end
        endcase
    end

    // Writes are gated by reset so an abandoned access never lands in memory.
    assign dm_we = rst & retire & is_store & ~misalign;

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (dm_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i])
                    dm[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // MEM/WB register: capture on retirement, bubble while stalled.
    always_comb begin
        mw_memtoreg_d = mw_memtoreg_q;
        mw_regwrite_d = mw_regwrite_q;
        mw_aluout_d   = mw_aluout_q;
        mdr_d         = mdr_q;
        mw_rd_d       = mw_rd_q;
        mw_misalign_d = mw_misalign_q;
        if (retire) begin
            mw_memtoreg_d = bus.XM_MemtoReg;
            mw_regwrite_d = bus.XM_RegWrite & ~misalign;
            mw_aluout_d   = bus.ALUout;
            mw_rd_d       = bus.XM_RD;
            mw_misalign_d = misalign;
            if (is_load && !misalign)
                mdr_d = ld_ext;
        end else begin
            mw_memtoreg_d = 1'b0;
            mw_regwrite_d = 1'b0;
            mw_misalign_d = 1'b0;
        end
    end

    // MEM/WB register flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw_memtoreg_q <= 1'b0;
            mw_regwrite_q <= 1'b0;
            mw_aluout_q   <= 32'd0;
            mdr_q         <= 32'd0;
            mw_rd_q       <= 5'd0;
            mw_misalign_q <= 1'b0;
        end else begin
            mw_memtoreg_q <= mw_memtoreg_d;
            mw_regwrite_q <= mw_regwrite_d;
            mw_aluout_q   <= mw_aluout_d;
            mdr_q         <= mdr_d;
            mw_rd_q       <= mw_rd_d;
            mw_misalign_q <= mw_misalign_d;
        end
    end

    assign bus.MW_MemtoReg = mw_memtoreg_q;
    assign bus.MW_RegWrite = mw_regwrite_q;
    assign bus.MW_ALUout   = mw_aluout_q;
    assign bus.MDR         = mdr_q;
    assign bus.MW_RD       = mw_rd_q;
    assign bus.MW_Misalign = mw_misalign_q;
endmodule

// File: tb/tb_mem_stage_bw.sv
// Directed bench for mem_stage_bw: one single-cycle instance (MEM_LAT=0) and
// one instance with two wait cycles (MEM_LAT=2), sharing clock and reset.
module tb_mem_stage_bw;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_stage_bw_if if0 ();
    mem_stage_bw_if if2 ();
    logic       dbg_state0, dbg_state2;
    logic [2:0] dbg_cnt0, dbg_cnt2;

    mem_stage_bw #(.DEPTH(128), .MEM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .dbg_state(dbg_state0), .dbg_cnt(dbg_cnt0)
    );
    mem_stage_bw #(.DEPTH(128), .MEM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2.slave), .dbg_state(dbg_state2), .dbg_cnt(dbg_cnt2)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one EX/MEM word into the selected instance (0 or 2).
    task automatic drv(input int sel, input logic mr, input logic mw, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] md,
                       input logic rw, input logic m2r, input logic [4:0] rd);
        if (sel == 0) begin
            if0.XM_MemRead = mr; if0.XM_MemWrite = mw; if0.XM_Size = sz; if0.XM_Unsigned = uns;
            if0.ALUout = a; if0.XM_MD = md; if0.XM_RegWrite = rw; if0.XM_MemtoReg = m2r; if0.XM_RD = rd;
        end else begin
            if2.XM_MemRead = mr; if2.XM_MemWrite = mw; if2.XM_Size = sz; if2.XM_Unsigned = uns;
            if2.ALUout = a; if2.XM_MD = md; if2.XM_RegWrite = rw; if2.XM_MemtoReg = m2r; if2.XM_RD = rd;
        end
    endtask

    task automatic idle(input int sel);
        drv(sel, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    endtask

    // Single-cycle access on dut0: drive, retire on next edge, then idle inputs.
    task automatic acc0(input logic mr, input logic mw, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] md);
        drv(0, mr, mw, sz, uns, a, md, mr & ~mw, mr & ~mw, 5'd3);
        tick();
        idle(0);
    endtask

    // Access on dut2: hold inputs until mem_stall drops (bounded), retire, idle.
    task automatic acc2(input logic mr, input logic mw, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] md);
        int budget;
        drv(2, mr, mw, sz, uns, a, md, mr & ~mw, mr & ~mw, 5'd4);
        #1;
        budget = 0;
        while (if2.mem_stall === 1'b1 && budget < 16) begin
            tick();
            budget++;
        end
        n_checks++;
        if (if2.mem_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL acc2_timeout: mem_stall=%b still high after %0d cycles, required 0", if2.mem_stall, budget);
        end
        tick();
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(0);
        idle(2);
        repeat (2) tick();
        n_checks++; if (if0.MW_RegWrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite0: got %b want 0", if0.MW_RegWrite); end
        n_checks++; if (if0.MDR !== 32'd0) begin n_fail++; $display("FAIL rst_mdr0: got %h want 00000000", if0.MDR); end
        n_checks++; if (if2.MW_ALUout !== 32'd0) begin n_fail++; $display("FAIL rst_aluout2: got %h want 00000000", if2.MW_ALUout); end
        n_checks++; if (if2.mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall2: got %b want 0", if2.mem_stall); end
        n_checks++; if (dbg_state2 !== 1'b0) begin n_fail++; $display("FAIL rst_state2: got %b want 0", dbg_state2); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_byte_loads();
        acc0(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'h8899AABB);
        acc0(1'b1, 1'b0, SZ_B, 1'b0, 32'h11, 32'h0);
        n_checks++; if (if0.MDR !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_signed: got %h want FFFFFFAA", if0.MDR); end
        n_checks++; if (if0.MW_RegWrite !== 1'b1) begin n_fail++; $display("FAIL lb_regwrite: got %b want 1", if0.MW_RegWrite); end
        acc0(1'b1, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0);
        n_checks++; if (if0.MDR !== 32'h00000088) begin n_fail++; $display("FAIL lbu: got %h want 00000088", if0.MDR); end
        acc0(1'b1, 1'b0, SZ_H, 1'b0, 32'h12, 32'h0);
        n_checks++; if (if0.MDR !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh_signed: got %h want FFFF8899", if0.MDR); end
    endtask

    task automatic test_half_store();
        acc0(1'b0, 1'b1, SZ_W, 1'b0, 32'h20, 32'hFFFFFFFF);
        acc0(1'b0, 1'b1, SZ_H, 1'b0, 32'h22, 32'hABCD1234);
        acc0(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        n_checks++; if (if0.MDR !== 32'h1234FFFF) begin n_fail++; $display("FAIL sh_lw: got %h want 1234FFFF", if0.MDR); end
        acc0(1'b1, 1'b0, SZ_H, 1'b0, 32'h22, 32'h0);
        n_checks++; if (if0.MDR !== 32'h00001234) begin n_fail++; $display("FAIL sh_lh: got %h want 00001234", if0.MDR); end
        acc0(1'b0, 1'b1, SZ_B, 1'b0, 32'h21, 32'hFFFFFF5A);
        acc0(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        n_checks++; if (if0.MDR !== 32'h12345AFF) begin n_fail++; $display("FAIL sb_lw: got %h want 12345AFF", if0.MDR); end
    endtask

    task automatic test_misalign();
        drv(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h06, 32'h0, 1'b1, 1'b1, 5'd9);
        tick();
        idle(0);
        n_checks++; if (if0.MW_Misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", if0.MW_Misalign); end
        n_checks++; if (if0.MW_RegWrite !== 1'b0) begin n_fail++; $display("FAIL mis_regwrite: got %b want 0", if0.MW_RegWrite); end
        n_checks++; if (if0.MDR !== 32'h12345AFF) begin n_fail++; $display("FAIL mis_mdr_hold: got %h want 12345AFF", if0.MDR); end
        n_checks++; if (if0.MW_RD !== 5'd9) begin n_fail++; $display("FAIL mis_rd: got %0d want 9", if0.MW_RD); end
        n_checks++; if (if0.MW_ALUout !== 32'h06) begin n_fail++; $display("FAIL mis_aluout: got %h want 00000006", if0.MW_ALUout); end
        acc0(1'b0, 1'b1, SZ_W, 1'b0, 32'h22, 32'h00000000);
        acc0(1'b0, 1'b1, SZ_H, 1'b0, 32'h21, 32'h00000000);
        acc0(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        n_checks++; if (if0.MDR !== 32'h12345AFF) begin n_fail++; $display("FAIL mis_store_nowrite: got %h want 12345AFF", if0.MDR); end
        n_checks++; if (if0.MW_Misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", if0.MW_Misalign); end
        // MemRead and MemWrite together act as a store; MDR must hold.
        acc0(1'b1, 1'b1, SZ_B, 1'b0, 32'h20, 32'h00000077);
        n_checks++; if (if0.MDR !== 32'h12345AFF) begin n_fail++; $display("FAIL rw_mdr_hold: got %h want 12345AFF", if0.MDR); end
        acc0(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        n_checks++; if (if0.MDR !== 32'h12345A77) begin n_fail++; $display("FAIL rw_store: got %h want 12345A77", if0.MDR); end
    endtask

    task automatic test_wrap();
        acc0(1'b0, 1'b1, SZ_W, 1'b0, 32'h204, 32'hDEADBEEF);
        acc0(1'b1, 1'b0, SZ_W, 1'b0, 32'h004, 32'h0);
        n_checks++; if (if0.MDR !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wrap: got %h want DEADBEEF", if0.MDR); end
    endtask

    task automatic test_latency();
        acc2(1'b0, 1'b1, SZ_W, 1'b0, 32'h40, 32'hCAFEF00D);
        drv(2, 1'b1, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 5'd5);
        #1;
        n_checks++; if (if2.mem_stall !== 1'b1) begin n_fail++; $display("FAIL lat_stall_c0: got %b want 1", if2.mem_stall); end
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_checks++; if (if2.MW_RegWrite !== 1'b0 || if2.MW_MemtoReg !== 1'b0 || if2.MW_Misalign !== 1'b0) begin
                n_fail++; $display("FAIL lat_bubble_%0d: got rw=%b m2r=%b mis=%b want 0 0 0", c, if2.MW_RegWrite, if2.MW_MemtoReg, if2.MW_Misalign);
            end
            n_checks++; if (if2.mem_stall !== (c == 1)) begin n_fail++; $display("FAIL lat_stall_c%0d: got %b want %b", c, if2.mem_stall, (c == 1)); end
        end
        tick();
        n_checks++; if (if2.MDR !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat_mdr: got %h want CAFEF00D", if2.MDR); end
        n_checks++; if (if2.MW_RegWrite !== 1'b1 || if2.MW_RD !== 5'd5) begin n_fail++; $display("FAIL lat_retire: got rw=%b rd=%0d want 1 5", if2.MW_RegWrite, if2.MW_RD); end
        drv(2, 1'b0, 1'b0, SZ_W, 1'b0, 32'h99, 32'h0, 1'b1, 1'b0, 5'd7);
        #1;
        n_checks++; if (if2.mem_stall !== 1'b0) begin n_fail++; $display("FAIL lat_alu_stall: got %b want 0", if2.mem_stall); end
        tick();
        idle(2);
        n_checks++; if (if2.MW_RD !== 5'd7 || if2.MW_ALUout !== 32'h99 || if2.MW_MemtoReg !== 1'b0) begin
            n_fail++; $display("FAIL lat_alu_retire: got rd=%0d alu=%h m2r=%b want 7 00000099 0", if2.MW_RD, if2.MW_ALUout, if2.MW_MemtoReg);
        end
        n_checks++; if (if2.MDR !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat_alu_mdr: got %h want CAFEF00D", if2.MDR); end
    endtask

    task automatic test_reset_mid_wait();
        acc2(1'b0, 1'b1, SZ_W, 1'b0, 32'h50, 32'h11111111);
        drv(2, 1'b0, 1'b1, SZ_W, 1'b0, 32'h50, 32'h22222222, 1'b0, 1'b0, 5'd6);
        tick();
        n_checks++; if (dbg_state2 !== 1'b1) begin n_fail++; $display("FAIL mid_in_wait: got %b want 1", dbg_state2); end
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (if2.mem_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall: got %b want 0", if2.mem_stall); end
        n_checks++; if (if2.MW_ALUout !== 32'd0 || if2.MW_RD !== 5'd0 || if2.MDR !== 32'd0) begin
            n_fail++; $display("FAIL mid_rst_outs: got alu=%h rd=%0d mdr=%h want 0 0 0", if2.MW_ALUout, if2.MW_RD, if2.MDR);
        end
        n_checks++; if (dbg_state2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got %b want 0", dbg_state2); end
        tick();
        tick();
        idle(2);
        #1;
        rst = 1'b1;
        tick();
        acc2(1'b1, 1'b0, SZ_W, 1'b0, 32'h50, 32'h0);
        n_checks++; if (if2.MDR !== 32'h11111111) begin n_fail++; $display("FAIL mid_no_write: got %h want 11111111", if2.MDR); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_byte_loads();
        test_half_store();
        test_misalign();
        test_wrap();
        test_latency();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_bw.md
Name: mem_stage_bw

Overview:
- Parametrised MEM pipeline stage for the MIPS core: data memory plus the MEM/WB pipeline register.
- Adds the following to the current single-cycle word-only stage:
  - configurable memory depth;
  - byte, halfword and word loads and stores;
  - signed and unsigned load extension;
  - misalignment trapping;
  - a configurable access latency, with a stall handshake back to the hazard unit.
- Sits between the EX/MEM register and the WB mux.

Parameters:
- DEPTH, 128, data memory size in 32-bit words; power of two, 4 to 4096.
- MEM_LAT, 0, extra wait cycles per memory access (0 to 7). 0 gives single-cycle behaviour.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- XM_MemtoReg  in  1  WB selects MDR.
- XM_RegWrite  in  1  WB writes the register file.
- XM_MemRead  in  1  load in this stage.
- XM_MemWrite  in  1  store in this stage.
- XM_Size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- XM_Unsigned  in  1  load zero-extends (1) or sign-extends (0).
- ALUout  in  32  effective byte address / ALU result.
- XM_RD  in  5  destination register.
- XM_MD  in  32  store data, right-aligned.
- MW_MemtoReg  out  1  registered.
- MW_RegWrite  out  1  registered.
- MW_ALUout  out  32  registered.
- MDR  out  32  registered, extended load data.
- MW_RD  out  5  registered.
- MW_Misalign  out  1  registered; the retired access was misaligned.
- mem_stall  out  1  combinational; upstream must hold the XM_* inputs and ALUout.

Behaviour:
- Reset (rst=0, asynchronous):
  - All MW_* outputs and MDR go to 0; MW_Misalign goes to 0.
  - The FSM goes to IDLE and the wait counter goes to 0.
  - DM contents are not reset.
- Addressing:
  - Word index = ALUout[AW+1:2], where AW = log2(DEPTH).
  - Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = ALUout[1:0]. Lane 0 is bits 7:0 (little-endian).
- Misaligned access:
  - Half with ALUout[0]=1, or word with ALUout[1:0]!=0.
  - No DM write. MDR holds its value.
  - MW_RegWrite is forced to 0 and MW_Misalign is set to 1 for that retirement.
  - Other MW_* fields still capture the inputs normally.
- Stores write only the addressed lanes:
  - byte: XM_MD[7:0] to the selected lane;
  - half: XM_MD[15:0] to lanes {1,0} or {3,2};
  - word: all 4 lanes.
- Loads:
  - Select the byte or half from the addressed lanes.
  - Sign-extend or zero-extend to 32 bits per XM_Unsigned.
  - Word loads pass through.
- MDR update rule: MDR updates only on retirement of an aligned load; otherwise it holds.
- A "memory access" is XM_MemRead or XM_MemWrite being 1.
  - If both are 1, it is a store. MDR holds and no load data is captured.
- MEM_LAT=0: every cycle retires. DM write and MW capture occur on the same edge. mem_stall is always 0.
- MEM_LAT>0, FSM states IDLE and WAIT:
  - IDLE with an access: mem_stall=1. At the edge, go to WAIT with cnt=MEM_LAT-1. The MW register loads a bubble (MW_RegWrite=0, MW_MemtoReg=0, MW_Misalign=0; other fields are don't-care and the bench must not check them).
  - WAIT with cnt!=0: mem_stall=1. At the edge, cnt decrements and a bubble is loaded.
  - WAIT with cnt==0: mem_stall=0. At the edge the access retires (DM write or MDR capture, plus MW capture) and the FSM returns to IDLE.
  - IDLE with no access: mem_stall=0. Retires every cycle (pass-through).
  - Result: an access occupies MEM_LAT+1 cycles, with mem_stall high for exactly MEM_LAT of them.
  - A misaligned access takes the same latency.
- Reset mid-WAIT: the access is abandoned, no DM write occurs, and the FSM returns to IDLE.
- A load immediately following a store to the same word sees the stored data, because the store retires before the load is sampled.

Test Plan:
- Reset with rst=0 while in WAIT -> all outputs 0 and mem_stall=0. After release, no DM write has occurred (a word read of the address returns its prior value).
- MEM_LAT=0: SW 0x8899AABB at 0x10, then LB (signed) at 0x11 and LBU at 0x13 -> MDR=0xFFFFFFAA, then 0x00000088.
- SH 0x1234 at 0x22 over word 0xFFFFFFFF, then LW 0x20 -> MDR=0x1234FFFF. Then LH at 0x22 -> 0x00001234.
- LW at 0x06 with XM_RegWrite=1 -> MW_Misalign=1, MW_RegWrite=0, MDR unchanged, DM unchanged.
- MEM_LAT=2: LW issued, then an ALU op -> mem_stall=1 for 2 cycles, then 0; bubbles for 2 edges; MDR valid on the 3rd edge; the ALU op retires 1 cycle later.
- DEPTH=128: SW 0xDEADBEEF at 0x204 (wraps), then LW at 0x004 -> MDR=0xDEADBEEF.
